// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4:1 mux: steps the select lines through codes 0..3, samples the mux
// output after DWELL cycles per code, and presents the assembled 4-bit frame via valid/ready.
module mux_scan_ctrl #(
  parameter int DWELL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       mux_in,
  input  logic       ready,
  output logic       s0,
  output logic       s1,
  output logic [3:0] data,
  output logic       valid,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  localparam logic [3:0] DW_LAST = 4'(DWELL - 1);

  state_t      state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  dwell_q, dwell_d;
  logic [3:0]  shadow_q, shadow_d;
  logic [3:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    sel_d       = sel_q;
    dwell_d     = dwell_q;
    shadow_d    = shadow_q;
    data_d      = data_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          ch_d    = 2'd0;
          dwell_d = 4'd0;
          sel_d   = 2'd0;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (dwell_q == DW_LAST) begin
          shadow_d[ch_q] = mux_in;
          dwell_d        = 4'd0;
          ch_d           = ch_q + 2'd1;
          sel_d          = ch_q + 2'd1;
          // Last channel: the frame includes the bit captured on this very edge.
          if (ch_q == 2'd3) begin
            data_d  = shadow_d;
            valid_d = 1'b1;
            sel_d   = 2'b11;
            state_d = HOLD;
          end
        end else begin
          dwell_d = dwell_q + 4'd1;
        end
      end
      HOLD: begin
        if (ready) begin
          valid_d     = 1'b0;
          frame_cnt_d = frame_cnt_q + 8'd1;
          ch_d        = 2'd0;
          dwell_d     = 4'd0;
          sel_d       = 2'd0;
          if (cont) begin
            state_d = SCAN;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 2'd0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= 2'd0;
      sel_q       <= 2'd0;
      dwell_q     <= 4'd0;
      shadow_q    <= 4'd0;
      data_q      <= 4'd0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      sel_q       <= sel_d;
      dwell_q     <= dwell_d;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign s0        = sel_q[0];
  assign s1        = sel_q[1];
  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances (DWELL=1,2,3) share stimulus, each checked every
// cycle against a frame-level model, plus directed literal checks for the key scenarios.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] iv = 4'd0;

  logic       s0_w [3];
  logic       s1_w [3];
  logic       mux_in_w [3];
  logic [3:0] data_w [3];
  logic       valid_w [3];
  logic       busy_w [3];
  logic [7:0] frame_cnt_w [3];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int D = g + 1;

    mux_scan_ctrl #(.DWELL(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .cont      (cont),
      .mux_in    (mux_in_w[g]),
      .s0        (s0_w[g]),
      .s1        (s1_w[g]),
      .data      (data_w[g]),
      .valid     (valid_w[g]),
      .ready     (ready),
      .busy      (busy_w[g]),
      .frame_cnt (frame_cnt_w[g])
    );

    // Emulated downstream mux: input i is iv[i].
    assign mux_in_w[g] = iv[{s1_w[g], s0_w[g]}];

    // Model: mode 0 idle, 1 scanning (t = cycles since scan began), 2 holding a frame.
    int         mode = 0;
    int         t = 0;
    logic [3:0] sh = 4'd0;
    logic [3:0] md = 4'd0;
    logic       mv = 1'b0;
    logic [7:0] mc = 8'd0;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode = 0; t = 0; sh = 4'd0; md = 4'd0; mv = 1'b0; mc = 8'd0;
      end else begin
        case (mode)
          0: if (start) begin mode = 1; t = 0; end
          1: begin
            if (t % D == D - 1) sh[t / D] = iv[t / D];
            t++;
            if (t == 4 * D) begin md = sh; mv = 1'b1; mode = 2; end
          end
          default: if (ready) begin
            mv = 1'b0; mc = mc + 8'd1; t = 0;
            mode = cont ? 1 : 0;
          end
        endcase
      end
    end

    always @(posedge clk) begin
      int exp_sel;
      #3;
      exp_sel = (mode == 1) ? t / D : (mode == 2) ? 3 : 0;
      chk($sformatf("sel_d%0d", D), 32'({s1_w[g], s0_w[g]}), 32'(exp_sel));
      chk($sformatf("data_d%0d", D), 32'(data_w[g]), 32'(md));
      chk($sformatf("valid_d%0d", D), 32'(valid_w[g]), 32'(mv));
      chk($sformatf("busy_d%0d", D), 32'(busy_w[g]), 32'(mode != 0));
      chk($sformatf("fcnt_d%0d", D), 32'(frame_cnt_w[g]), 32'(mc));
    end
  end

  initial begin
    logic [3:0] held;
    int hs, last_rise, gaps, bound;
    logic prev_v2;

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_data", 32'(data_w[k]), 32'd0);
      chk("rst_valid", 32'(valid_w[k]), 32'd0);
      chk("rst_busy", 32'(busy_w[k]), 32'd0);
      chk("rst_fcnt", 32'(frame_cnt_w[k]), 32'd0);
      chk("rst_sel", 32'({s1_w[k], s0_w[k]}), 32'd0);
    end

    // Single frame, start in the same cycle as reset release; i0..i3 = 1,0,1,1
    rst_n = 1'b1; start = 1'b1; ready = 1'b1; cont = 1'b0; iv = 4'b1101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      chk("single_sel", 32'({s1_w[0], s0_w[0]}), 32'(k));
      chk("single_novalid", 32'(valid_w[0]), 32'd0);
    end
    @(negedge clk);
    chk("single_valid", 32'(valid_w[0]), 32'd1);
    chk("single_data", 32'(data_w[0]), 32'b1101);
    @(negedge clk);
    chk("single_done_valid", 32'(valid_w[0]), 32'd0);
    chk("single_fcnt", 32'(frame_cnt_w[0]), 32'd1);
    chk("single_idle", 32'(busy_w[0]), 32'd0);
    repeat (20) @(negedge clk);

    // Backpressure
    ready = 1'b0; start = 1'b1; iv = 4'b0110;
    bound = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      bound++;
    end while (!valid_w[0] && bound < 20);
    chk("bp_valid_seen", 32'(valid_w[0]), 32'd1);
    chk("bp_data", 32'(data_w[0]), 32'b0110);
    held = data_w[0];
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(valid_w[0]), 32'd1);
      chk("bp_hold_data", 32'(data_w[0]), 32'(held));
      chk("bp_hold_sel", 32'({s1_w[0], s0_w[0]}), 32'd3);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("bp_release_valid", 32'(valid_w[0]), 32'd0);
    chk("bp_single_hs", 32'(frame_cnt_w[0]), 32'd2);
    ready = 1'b1;
    repeat (20) @(negedge clk);

    // Reset while the DWELL=3 instance scans channel 2
    start = 1'b1;
    bound = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      bound++;
    end while ({s1_w[2], s0_w[2]} != 2'd2 && bound < 30);
    chk("midscan_reached", 32'({s1_w[2], s0_w[2]}), 32'd2);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("arst_sel", 32'({s1_w[k], s0_w[k]}), 32'd0);
      chk("arst_data", 32'(data_w[k]), 32'd0);
      chk("arst_valid", 32'(valid_w[k]), 32'd0);
      chk("arst_busy", 32'(busy_w[k]), 32'd0);
      chk("arst_fcnt", 32'(frame_cnt_w[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk("post_rst_novalid", 32'(valid_w[k]), 32'd0);
    end

    // Continuous mode with random inputs and start pulses while busy; frame_cnt wrap
    cont = 1'b1; ready = 1'b1; start = 1'b1;
    hs = 0; last_rise = -1; gaps = 0; prev_v2 = 1'b0; bound = 0;
    while (hs < 257 && bound < 3000) begin
      @(negedge clk);
      bound++;
      start = 1'($urandom_range(0, 1));
      iv = 4'($urandom);
      if (valid_w[0] && ready) hs++;
      if (valid_w[2] && !prev_v2) begin
        if (last_rise >= 0 && gaps < 6) begin
          chk("cont_spacing_d3", 32'(cyc - last_rise), 32'd13);
          gaps++;
        end
        last_rise = cyc;
      end
      prev_v2 = valid_w[2];
    end
    chk("wrap_hs_count", 32'(hs), 32'd257);
    @(negedge clk);
    chk("wrap_fcnt", 32'(frame_cnt_w[0]), 32'd1);

    // Fully random operation
    repeat (2000) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      cont  = 1'($urandom_range(0, 1));
      ready = ($urandom_range(0, 2) != 0);
      iv    = 4'($urandom);
      rst_n = ($urandom_range(0, 249) != 0);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
